// File: rtl/avr_tx_arbiter.sv
// avr_tx_arbiter: message-granular round-robin arbiter for the shared FPGA->AVR serial transmit path.
// Optional macro TX_ARB_TIMEOUT_EN releases a grant whose owner stays idle for TIMEOUT_CYC locked cycles.
module avr_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_new_data,
    input  logic                 tx_busy,
    input  logic                 avr_rx_busy,
    output logic                 grant_valid,
    output logic [2:0]           grant_id
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("avr_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] grant_id_q, grant_id_d;
    logic [2:0] ptr_q, ptr_d, ptr_next;
    logic       grant_valid_q, grant_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_new_q, tx_new_d;
    logic       last_q, last_d;

    logic       sel_valid, sel_last;
    logic [7:0] sel_data;
    logic       pick_found;
    logic [2:0] pick_id;
    logic       accept;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    // Granted requester's byte; everybody else's data/last is ignored.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == 3'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && (i == (int'(ptr_q) + k) % NUM_REQ) && req_valid[i]) begin
                    pick_found = 1'b1;
                    pick_id    = 3'(i);
                end
            end
        end
    end

    assign ptr_next = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
    assign accept   = (state_q == LOCKED) && sel_valid && !tx_busy && !avr_rx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            ptr_q         <= '0;
            grant_valid_q <= 1'b0;
            tx_data_q     <= '0;
            tx_new_q      <= 1'b0;
            last_q        <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
            idle_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            ptr_q         <= ptr_d;
            grant_valid_q <= grant_valid_d;
            tx_data_q     <= tx_data_d;
            tx_new_q      <= tx_new_d;
            last_q        <= last_d;
`ifdef TX_ARB_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        grant_valid_d = grant_valid_q;
        tx_data_d     = tx_data_q;
        tx_new_d      = 1'b0;
        last_d        = last_q;
`ifdef TX_ARB_TIMEOUT_EN
        idle_cnt_d    = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    state_d       = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    tx_data_d = sel_data;
                    tx_new_d  = 1'b1;
                    last_d    = sel_last;
                    state_d   = GAP;
                end
`ifdef TX_ARB_TIMEOUT_EN
                else if (!sel_valid) begin
                    if (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        grant_valid_d = 1'b0;
                        ptr_d         = ptr_next;
                        state_d       = IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
`endif
            end
            GAP: begin
                // One dead cycle per byte lets the serializer raise tx_busy.
                if (last_q) begin
                    grant_valid_d = 1'b0;
                    ptr_d         = ptr_next;
                    state_d       = IDLE;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == LOCKED) && (grant_id_q == 3'(i)) && !tx_busy && !avr_rx_busy;
        end
        tx_data     = tx_data_q;
        tx_new_data = tx_new_q;
        grant_valid = grant_valid_q;
        grant_id    = grant_id_q;
    end

endmodule

// File: tb/tb_avr_tx_arbiter.sv
// Bench for avr_tx_arbiter: directed message scenarios checked by a rule-level model every cycle.
module tb_avr_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic [7:0]   tx_data;
    logic         tx_new_data;
    logic         tx_busy;
    logic         avr_rx_busy;
    logic         grant_valid;
    logic [2:0]   grant_id;

    avr_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_new_data(tx_new_data),
        .tx_busy(tx_busy), .avr_rx_busy(avr_rx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int logq[$];
    int ev[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Rule-level model: grant owner, pending strobe, round-robin pointer.
    bit       m_gv, m_gap, m_last, m_new, s_ok;
    int       m_gid, m_ptr, m_txd, m_idle;
    logic [N-1:0]   s_valid, s_last;
    logic [8*N-1:0] s_data;
    logic     s_txb, s_avb;
    int       exp_rdy;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_gv = 0; m_gap = 0; m_last = 0; m_new = 0;
            m_gid = 0; m_ptr = 0; m_txd = 0; m_idle = 0; s_ok = 0;
            chk("reset_outputs", int'({req_ready, tx_data, tx_new_data, grant_valid, grant_id}), 0);
        end else begin
            m_new = 0;
            if (s_ok) begin
                if (m_gap) begin
                    m_gap = 0;
                    if (m_last) begin
                        m_gv  = 0;
                        m_ptr = (m_gid + 1) % N;
                    end
                end else if (m_gv) begin
                    if (((s_valid >> m_gid) & 1) != 0 && !s_txb && !s_avb) begin
                        m_new  = 1;
                        m_gap  = 1;
                        m_txd  = int'((s_data >> (8 * m_gid)) & 8'hFF);
                        m_last = ((s_last >> m_gid) & 1) != 0;
                        m_idle = 0;
                    end
`ifdef TX_ARB_TIMEOUT_EN
                    else if (((s_valid >> m_gid) & 1) != 0) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == TO) begin
                            m_gv   = 0;
                            m_ptr  = (m_gid + 1) % N;
                            m_idle = 0;
                        end
                    end
`endif
                end else begin
                    for (int k = 0; k < N; k++) begin
                        int j;
                        j = (m_ptr + k) % N;
                        if (!m_gv && ((s_valid >> j) & 1) != 0) begin
                            m_gv  = 1;
                            m_gid = j;
                        end
                    end
                end
            end
            exp_rdy = (m_gv && !m_gap && !tx_busy && !avr_rx_busy) ? (1 << m_gid) : 0;
            chk("req_ready", int'(req_ready), exp_rdy);
            chk("tx_new_data", int'(tx_new_data), int'(m_new));
            chk("tx_data", int'(tx_data), m_txd);
            chk("grant_valid", int'(grant_valid), int'(m_gv));
            chk("grant_id", int'(grant_id), m_gid);
            if (tx_new_data) logq.push_back(int'(tx_data));
            s_valid = req_valid; s_last = req_last; s_data = req_data;
            s_txb = tx_busy; s_avb = avr_rx_busy; s_ok = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
        for (int i = 0; i < N; i++) begin
            if (i == r) begin
                req_valid[i]       = v;
                req_data[8*i +: 8] = d;
                req_last[i]        = l;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        tx_busy = 1'b0; avr_rx_busy = 1'b0;
        repeat (3) tick();
        logq.delete();
        rst_n = 1'b1;
    endtask

    // Returns one cycle after the accepting edge (the strobe cycle).
    task automatic wait_acc(input logic [N-1:0] mask, input string name);
        bit done;
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if ((req_valid & req_ready & mask) != 0) done = 1;
        end
        if (done) tick();
        else begin
            total++; bad++;
            $display("FAIL %s: no acceptance seen, required one within 300 cycles", name);
        end
    endtask

    task automatic chk_log(input string name, input int n);
        chk({name, "_len"}, logq.size(), n);
        for (int i = 0; i < n && i < logq.size(); i++) chk(name, logq[i], ev[i]);
    endtask

    initial begin
        int viol;
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        tx_busy = 1'b0; avr_rx_busy = 1'b0;

        // reset held with every requester valid
        req_valid = 4'hF; req_last = 4'hF; req_data = 32'h1312_1110;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_hold", int'({req_ready, tx_data, tx_new_data, grant_valid, grant_id}), 0);
        tick();
        logq.delete();
        rst_n = 1'b1;
        tick();
        chk("rst_grant_valid", int'(grant_valid), 1);
        chk("rst_grant_id", int'(grant_id), 0);
        wait_acc(4'b0001, "rst_acc");
        req_valid = '0;
        repeat (3) tick();
        ev = '{'h10, 0, 0, 0, 0, 0, 0, 0};
        chk_log("rst_log", 1);

        // round robin between 0 and 2
        do_reset();
        set_req(0, 1'b1, 8'hA0, 1'b1);
        set_req(2, 1'b1, 8'hC2, 1'b1);
        for (int b = 0; b < 6; b++) wait_acc(4'b0101, "rr_acc");
        req_valid = '0;
        repeat (4) tick();
        ev = '{'hA0, 'hC2, 'hA0, 'hC2, 'hA0, 'hC2, 0, 0};
        chk_log("rr_log", 6);

        // message lock: requester 1 holds the grant until last
        do_reset();
        set_req(3, 1'b1, 8'h33, 1'b1);
        set_req(1, 1'b1, 8'h11, 1'b0);
        wait_acc(4'b0010, "lock_acc1");
        set_req(1, 1'b1, 8'h12, 1'b0);
        wait_acc(4'b0010, "lock_acc2");
        set_req(1, 1'b1, 8'h13, 1'b1);
        wait_acc(4'b0010, "lock_acc3");
        set_req(1, 1'b0, 8'h00, 1'b0);
        wait_acc(4'b1000, "lock_acc4");
        req_valid = '0;
        repeat (3) tick();
        ev = '{'h11, 'h12, 'h13, 'h33, 0, 0, 0, 0};
        chk_log("lock_log", 4);

        // back-pressure from avr_rx_busy, then tx_busy
        do_reset();
        set_req(2, 1'b1, 8'h21, 1'b0);
        wait_acc(4'b0100, "bp_acc1");
        set_req(2, 1'b1, 8'h22, 1'b0);
        wait_acc(4'b0100, "bp_acc2");
        set_req(2, 1'b1, 8'h23, 1'b0);
        tick();
        avr_rx_busy = 1'b1;
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 0 || tx_new_data) viol++;
            tick();
        end
        avr_rx_busy = 1'b0;
        chk("avr_window", viol, 0);
        @(negedge clk);
        chk("avr_resume", int'(req_ready), 4);
        tick();
        set_req(2, 1'b1, 8'h24, 1'b1);
        tick();
        tx_busy = 1'b1;
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 0 || tx_new_data) viol++;
            tick();
        end
        tx_busy = 1'b0;
        chk("txb_window", viol, 0);
        @(negedge clk);
        chk("txb_resume", int'(req_ready), 4);
        tick();
        req_valid = '0;
        repeat (3) tick();
        ev = '{'h21, 'h22, 'h23, 'h24, 0, 0, 0, 0};
        chk_log("bp_log", 4);

        // reset mid-message after byte 2 of 4, with ptr moved off 0
        do_reset();
        set_req(1, 1'b1, 8'h40, 1'b1);
        wait_acc(4'b0010, "mid_acc0");
        req_valid = '0;
        repeat (3) tick();
        set_req(1, 1'b1, 8'h41, 1'b0);
        wait_acc(4'b0010, "mid_acc1");
        set_req(1, 1'b1, 8'h42, 1'b0);
        wait_acc(4'b0010, "mid_acc2");
        chk("mid_strobe_pre", int'(tx_new_data), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_async_clear", int'({req_ready, tx_data, tx_new_data, grant_valid, grant_id}), 0);
        repeat (3) tick();
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        set_req(0, 1'b1, 8'h50, 1'b1);
        set_req(3, 1'b1, 8'h53, 1'b1);
        tick();
        chk("mid_ptr_reset_gv", int'(grant_valid), 1);
        chk("mid_ptr_reset_id", int'(grant_id), 0);
        wait_acc(4'b0001, "mid_acc_r0");
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_acc(4'b1000, "mid_acc_r3");
        req_valid = '0;
        repeat (3) tick();
        ev = '{'h40, 'h41, 'h50, 'h53, 0, 0, 0, 0};
        chk_log("mid_log", 4);

        // owner goes idle mid-message while requester 1 waits
        do_reset();
        set_req(0, 1'b1, 8'h60, 1'b0);
        wait_acc(4'b0001, "to_acc0");
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b1, 8'h61, 1'b1);
`ifdef TX_ARB_TIMEOUT_EN
        wait_acc(4'b0010, "to_acc1");
        req_valid = '0;
        repeat (3) tick();
        ev = '{'h60, 'h61, 0, 0, 0, 0, 0, 0};
        chk_log("to_log", 2);
`else
        repeat (30) tick();
        @(negedge clk);
        chk("hold_gv", int'(grant_valid), 1);
        chk("hold_id", int'(grant_id), 0);
        chk("hold_ready", int'(req_ready), 1);
        tick();
        set_req(0, 1'b1, 8'h62, 1'b1);
        wait_acc(4'b0001, "hold_acc0");
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_acc(4'b0010, "hold_acc1");
        req_valid = '0;
        repeat (3) tick();
        ev = '{'h60, 'h62, 'h61, 0, 0, 0, 0, 0};
        chk_log("hold_log", 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
